// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C codec configuration path: sequencer state
// encoding, frame width and the default codec write address.
package i2c_cfg_pkg;

    // One I2C register write: {device address, register word}.
    localparam int I2C_FRAME_W = 24;

    // 7-bit codec address 0x1A shifted left with R/W=0.
    localparam logic [7:0] CODEC_ADDR = 8'h34;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_NEXT  = 3'd5,
        ST_READY = 3'd6,
        ST_FAIL  = 3'd7
    } state_t;

endpackage

// File: rtl/i2c_reg_sequencer.sv
// Walks an external register table and writes every word to the codec
// through an i2c_controller. NACKed writes are retried, an idle gap follows
// every ACKed write, and afterwards single runtime writes are accepted.
// The whole table can be replayed with rerun.
module i2c_reg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int          NUM_ENTRIES = 11,
    parameter int          IDX_W       = 4,
    parameter logic [7:0]  DEV_ADDR    = CODEC_ADDR,
    parameter int          MAX_RETRIES = 3,
    parameter int          GAP_CYCLES  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [IDX_W-1:0]       tbl_index,
    input  logic [15:0]            tbl_data,
    input  logic                   rerun,
    input  logic                   wr_req,
    input  logic [15:0]            wr_data,
    output logic                   wr_ack,
    output logic [I2C_FRAME_W-1:0] i2c_data,
    output logic                   i2c_start,
    input  logic                   i2c_done,
    input  logic                   i2c_ack,
    output logic                   busy,
    output logic                   cfg_done,
    output logic                   cfg_error
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
    localparam logic [GAP_W-1:0]   GAP_LAST    = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t                   state_q,     state_d;
    logic [IDX_W-1:0]         tbl_index_q, tbl_index_d;
    logic [RETRY_W-1:0]       retry_q,     retry_d;
    logic [GAP_W-1:0]         gap_q,       gap_d;
    logic [I2C_FRAME_W-1:0]   i2c_data_q,  i2c_data_d;
    logic                     runtime_q,   runtime_d;
    logic                     cfg_done_q,  cfg_done_d;
    logic                     cfg_error_q, cfg_error_d;

    // Next-state and datapath decisions for the whole write sequence.
    always_comb begin
        state_d     = state_q;
        tbl_index_d = tbl_index_q;
        retry_d     = retry_q;
        gap_d       = gap_q;
        i2c_data_d  = i2c_data_q;
        runtime_d   = runtime_q;
        cfg_done_d  = cfg_done_q;
        cfg_error_d = cfg_error_q;

        case (state_q)
            ST_LOAD: begin
                i2c_data_d = {DEV_ADDR, tbl_data};
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_GUARD;
            // The controller may still show done from the previous transfer.
            ST_GUARD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i2c_done) begin
                    if (i2c_ack) begin
                        retry_d = '0;
                        state_d = (GAP_CYCLES == 0) ? ST_NEXT : ST_GAP;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        if (retry_d == RETRY_LIMIT) begin
                            cfg_error_d = 1'b1;
                            state_d     = ST_FAIL;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_NEXT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_NEXT: begin
                if (runtime_q) begin
                    runtime_d = 1'b0;
                    state_d   = ST_READY;
                end else if (tbl_index_q == LAST_IDX) begin
                    cfg_done_d = 1'b1;
                    state_d    = ST_READY;
                end else begin
                    tbl_index_d = tbl_index_q + IDX_W'(1);
                    state_d     = ST_LOAD;
                end
            end
            ST_READY, ST_FAIL: begin
                if (rerun) begin
                    cfg_done_d  = 1'b0;
                    cfg_error_d = 1'b0;
                    tbl_index_d = '0;
                    retry_d     = '0;
                    gap_d       = '0;
                    runtime_d   = 1'b0;
                    state_d     = ST_LOAD;
                end else if (wr_req && state_q == ST_READY) begin
                    i2c_data_d = {DEV_ADDR, wr_data};
                    runtime_d  = 1'b1;
                    retry_d    = '0;
                    state_d    = ST_ISSUE;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State register; reset drops straight into a fresh table pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            tbl_index_q <= '0;
            retry_q     <= '0;
            gap_q       <= '0;
            i2c_data_q  <= '0;
            runtime_q   <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tbl_index_q <= tbl_index_d;
            retry_q     <= retry_d;
            gap_q       <= gap_d;
            i2c_data_q  <= i2c_data_d;
            runtime_q   <= runtime_d;
            cfg_done_q  <= cfg_done_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign tbl_index = tbl_index_q;
    assign i2c_data  = i2c_data_q;
    assign i2c_start = (state_q == ST_ISSUE);
    assign wr_ack    = (state_q == ST_READY) && wr_req && !rerun;
    assign busy      = (state_q != ST_READY) && (state_q != ST_FAIL);
    assign cfg_done  = cfg_done_q;
    assign cfg_error = cfg_error_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural controller that
// logs every started frame and answers after a fixed latency.
module tb_i2c_reg_sequencer;

    localparam int RESP_LAT = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  tbl_index;
    logic [15:0] tbl_data;
    logic        rerun;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic [23:0] i2c_data;
    logic        i2c_start;
    logic        i2c_done;
    logic        i2c_ack;
    logic        busy;
    logic        cfg_done;
    logic        cfg_error;

    int vectors     = 0;
    int miscompares = 0;

    // Controller model state
    logic [23:0] start_log[$];
    int          resp_cnt   = 0;
    logic        done_r     = 1'b0;
    logic        ack_r      = 1'b1;
    logic        pend_ack   = 1'b1;
    logic        done_force = 1'b0;
    logic [15:0] nack_word  = 16'h0000;
    int          nack_left  = 0;

    always #5 clk = ~clk;

    i2c_reg_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .tbl_index (tbl_index),
        .tbl_data  (tbl_data),
        .rerun     (rerun),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .i2c_data  (i2c_data),
        .i2c_start (i2c_start),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error)
    );

    // Register table: distinct word per index
    function automatic logic [15:0] tbl_word(input int i);
        logic [15:0] w;
        w = 16'hA000 + 16'(i) * 16'h0101;
        return w;
    endfunction

    assign tbl_data = tbl_word(int'(tbl_index));
    assign i2c_done = done_r | done_force;
    assign i2c_ack  = done_force ? 1'b0 : ack_r;

    // Controller model: log starts, answer RESP_LAT cycles later
    always begin
        @(posedge clk);
        #2;
        done_r = 1'b0;
        if (reset) begin
            resp_cnt = 0;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) begin
                    done_r = 1'b1;
                    ack_r  = pend_ack;
                end
            end
            if (i2c_start) begin
                start_log.push_back(i2c_data);
                resp_cnt = RESP_LAT;
                if (nack_left > 0 && i2c_data[15:0] == nack_word) begin
                    pend_ack  = 1'b0;
                    nack_left = nack_left - 1;
                end else begin
                    pend_ack = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_starts(input int cnt, input string tag);
        int n;
        n = 0;
        while (start_log.size() < cnt && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(start_log.size() >= cnt), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_idx"},   32'(tbl_index), 32'd0);
        check({tag, "_data"},  32'(i2c_data),  32'd0);
        check({tag, "_start"}, 32'(i2c_start), 32'd0);
        check({tag, "_wrack"}, 32'(wr_ack),    32'd0);
        check({tag, "_done"},  32'(cfg_done),  32'd0);
        check({tag, "_err"},   32'(cfg_error), 32'd0);
        check({tag, "_busy"},  32'(busy),      32'd1);
    endtask

    task automatic pulse_rerun();
        rerun = 1'b1;
        tick();
        rerun = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        rerun   = 1'b0;
        wr_req  = 1'b0;
        wr_data = 16'h0000;

        // Reset state
        tick(); tick(); tick();
        check_reset_outputs("rst");
        start_log.delete();
        reset = 1'b0;

        // Full pass, all ACK
        wait_ready("pass1_ready");
        check("pass1_starts", 32'(start_log.size()), 32'd11);
        for (int i = 0; i < start_log.size(); i++) begin
            check($sformatf("pass1_frame%0d", i), 32'(start_log[i]), 32'({8'h34, tbl_word(i)}));
        end
        check("pass1_done", 32'(cfg_done), 32'd1);
        check("pass1_err",  32'(cfg_error), 32'd0);
        check("pass1_idx",  32'(tbl_index), 32'd10);
        $display("pass1: %0d starts, cfg_done=%0d", start_log.size(), cfg_done);

        // Entry 3 NACKed twice, then ACKed
        start_log.delete();
        nack_word = tbl_word(3);
        nack_left = 2;
        pulse_rerun();
        check("rerun_clr_done", 32'(cfg_done), 32'd0);
        check("rerun_busy",     32'(busy),     32'd1);
        wait_ready("retry_ready");
        check("retry_starts", 32'(start_log.size()), 32'd13);
        check("retry_f3a", 32'(start_log[3]), 32'h0034A303);
        check("retry_f3b", 32'(start_log[4]), 32'h0034A303);
        check("retry_f3c", 32'(start_log[5]), 32'h0034A303);
        check("retry_f4",  32'(start_log[6]), 32'h0034A404);
        check("retry_done", 32'(cfg_done),  32'd1);
        check("retry_err",  32'(cfg_error), 32'd0);
        $display("retry pass: %0d starts, cfg_done=%0d", start_log.size(), cfg_done);

        // Entry 5 NACKed three times -> FAIL
        start_log.delete();
        nack_word = tbl_word(5);
        nack_left = 3;
        pulse_rerun();
        wait_ready("fail_stop");
        check("fail_starts", 32'(start_log.size()), 32'd8);
        check("fail_f5c",  32'(start_log[7]), 32'h0034A505);
        check("fail_err",  32'(cfg_error), 32'd1);
        check("fail_done", 32'(cfg_done),  32'd0);
        check("fail_busy", 32'(busy),      32'd0);
        wr_req  = 1'b1;
        wr_data = 16'h1111;
        #1;
        check("fail_wrack", 32'(wr_ack), 32'd0);
        for (int i = 0; i < 40; i++) tick();
        wr_req = 1'b0;
        check("fail_nostart", 32'(start_log.size()), 32'd8);
        check("fail_still", 32'(busy), 32'd0);
        $display("fail: %0d starts, cfg_error=%0d", start_log.size(), cfg_error);

        // Rerun out of FAIL
        start_log.delete();
        pulse_rerun();
        check("unfail_err", 32'(cfg_error), 32'd0);
        wait_starts(1, "unfail_start");
        check("unfail_f0", 32'(start_log[0]), 32'h0034A000);
        wait_ready("unfail_ready");
        check("unfail_done", 32'(cfg_done), 32'd1);
        $display("rerun from fail: %0d starts, cfg_done=%0d", start_log.size(), cfg_done);

        // Runtime write 0x0479
        start_log.delete();
        wr_req  = 1'b1;
        wr_data = 16'h0479;
        #1;
        check("rt_wrack", 32'(wr_ack), 32'd1);
        tick();
        wr_req = 1'b0;
        check("rt_wrack_pulse", 32'(wr_ack), 32'd0);
        check("rt_data",  32'(i2c_data),  32'h00340479);
        check("rt_start", 32'(i2c_start), 32'd1);
        wait_ready("rt_ready");
        check("rt_starts", 32'(start_log.size()), 32'd1);
        check("rt_done",   32'(cfg_done), 32'd1);
        $display("runtime write: data=%h starts=%0d", start_log[0], start_log.size());

        // rerun and wr_req together: rerun wins
        start_log.delete();
        rerun   = 1'b1;
        wr_req  = 1'b1;
        wr_data = 16'h0555;
        #1;
        check("both_wrack", 32'(wr_ack), 32'd0);
        tick();
        rerun  = 1'b0;
        wr_req = 1'b0;
        check("both_idx",  32'(tbl_index), 32'd0);
        check("both_busy", 32'(busy),      32'd1);
        wait_starts(1, "both_start");
        check("both_f0", 32'(start_log[0]), 32'h0034A000);
        wait_ready("both_ready");
        check("both_starts", 32'(start_log.size()), 32'd11);
        $display("rerun+wr_req: %0d starts", start_log.size());

        // Stale done (with NACK) held through ISSUE/GUARD must be ignored
        start_log.delete();
        wr_req     = 1'b1;
        wr_data    = 16'h1234;
        done_force = 1'b1;
        tick();            // ISSUE
        wr_req = 1'b0;
        tick();            // GUARD
        tick();            // WAIT
        done_force = 1'b0;
        wait_ready("stale_ready");
        check("stale_starts", 32'(start_log.size()), 32'd1);
        check("stale_err",    32'(cfg_error), 32'd0);
        $display("stale done: %0d starts, cfg_error=%0d", start_log.size(), cfg_error);

        // Reset during WAIT of entry 7
        start_log.delete();
        pulse_rerun();
        wait_starts(8, "mid_start7");
        tick(); tick(); tick();
        check("mid_idx7", 32'(tbl_index), 32'd7);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        tick();
        reset = 1'b0;
        start_log.delete();
        wait_ready("mid_ready");
        check("mid_starts", 32'(start_log.size()), 32'd11);
        check("mid_f0",     32'(start_log[0]), 32'h0034A000);
        check("mid_done",   32'(cfg_done), 32'd1);
        $display("post-reset pass: %0d starts, cfg_done=%0d", start_log.size(), cfg_done);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
Parametrised I2C register-write sequencer that drives an external i2c_controller (24-bit frame, start/done/ack handshake). After reset it walks an external table of NUM_ENTRIES 16-bit register words and writes each to DEV_ADDR. It retries NACKed writes up to a limit, inserts a programmable gap between writes, and flags success or failure. Once configured, it accepts runtime single-register writes (e.g. volume changes) and can be re-triggered to replay the full table.

Parameters:
NUM_ENTRIES, 11, number of table words written per configuration pass (≥1)
IDX_W, 4, table index width; must satisfy 2**IDX_W ≥ NUM_ENTRIES
DEV_ADDR, 8'h34, 8-bit I2C write address placed in i2c_data[23:16]
MAX_RETRIES, 3, NACKed attempts allowed per word before failure (≥1)
GAP_CYCLES, 16, idle clk cycles after each ACKed write (0 = no gap)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
tbl_index  out  IDX_W  address to external combinational register table
tbl_data  in  16  table word at tbl_index, valid in the same cycle
rerun  in  1  pulse; replays the table from index 0 (honoured in READY/FAIL only)
wr_req  in  1  runtime write request (honoured in READY only)
wr_data  in  16  runtime register word, captured with wr_ack
wr_ack  out  1  one-cycle pulse: wr_req accepted
i2c_data  out  24  {DEV_ADDR, word} to controller
i2c_start  out  1  one-cycle start pulse to controller
i2c_done  in  1  controller transfer complete
i2c_ack  in  1  controller ACK result, valid when i2c_done=1
busy  out  1  1 in every state except READY and FAIL
cfg_done  out  1  table pass completed successfully (sticky until rerun/reset)
cfg_error  out  1  retries exhausted (sticky until rerun/reset)

Behaviour:
- Reset values: state=LOAD, tbl_index=0, retry count=0, gap count=0, i2c_data=0, i2c_start=0, wr_ack=0, cfg_done=0, cfg_error=0, busy=1; the table pass starts automatically.
- LOAD: i2c_data <= {DEV_ADDR, tbl_data}; go to ISSUE.
- ISSUE: i2c_start=1 for exactly this cycle; go to GUARD.
- GUARD: one cycle with i2c_done ignored, so a stale done from the prior transfer is not seen; go to WAIT.
- WAIT: stay until i2c_done=1, then:
  - If ack=1: clear the retry count and go to GAP (or NEXT if GAP_CYCLES=0).
  - If ack=0: increment the retry count. If the new count equals MAX_RETRIES, go to FAIL; otherwise go to ISSUE (same i2c_data).
- GAP: count GAP_CYCLES cycles, then go to NEXT.
- NEXT:
  - Runtime write just finished: go to READY.
  - Otherwise, if tbl_index == NUM_ENTRIES-1: set cfg_done=1, go to READY.
  - Otherwise: tbl_index+1, go to LOAD.
- READY:
  - rerun=1: clear cfg_done/cfg_error, tbl_index=0, go to LOAD. rerun has priority over wr_req; no wr_ack is issued that cycle.
  - Else wr_req=1: wr_ack=1 for one cycle, i2c_data <= {DEV_ADDR, wr_data}, mark runtime mode, go to ISSUE.
- FAIL: cfg_error=1 and i2c_start=0. Only rerun (same action as in READY) or reset exits. wr_req is ignored.
- Runtime writes use the same retry and gap rules. Exhausting retries during a runtime write enters FAIL; cfg_done stays 1, cfg_error is set.
- rerun/wr_req in any busy state are ignored (not queued).
- Reset mid-transfer returns to the reset state next cycle; the controller is expected to be reset alongside.
- Latency from an ACKed done to the next i2c_start: GAP_CYCLES+3 cycles (GAP, NEXT, LOAD, ISSUE).
- tbl_index never exceeds NUM_ENTRIES-1.

Decomposition:
- Shared package i2c_cfg_pkg holds:
  - the state enum (LOAD, ISSUE, GUARD, WAIT, GAP, NEXT, READY, FAIL);
  - the I2C frame width constant (24);
  - the codec address constant CODEC_ADDR=8'h34.
- No sub-module inside the block.
- The register table is a separate combinational module, av_codec_cfg_table. i2c_controller is instantiated by the parent, not inside this block.

Test Plan:
- All ACK, NUM_ENTRIES=11, GAP_CYCLES=16: exactly 11 i2c_start pulses; i2c_data[23:16]=8'h34 on each; cfg_done=1 after the 11th; busy=0; tbl_index=10.
- NACK on entry 3 twice then ACK, MAX_RETRIES=3: entry 3 is issued 3 times with identical i2c_data; the pass still completes with cfg_done=1 and cfg_error=0.
- NACK on entry 5 three times: 3 start pulses for entry 5; FAIL with cfg_error=1, busy=0; no further starts. Then rerun: flags clear and i2c_start is seen for index 0.
- In READY, wr_req with wr_data=16'h0479: wr_ack pulse; i2c_data=24'h340479; one start; returns to READY with cfg_done still 1.
- rerun and wr_req in the same READY cycle: no wr_ack; the table restarts at index 0.
- i2c_done held high through ISSUE/GUARD: not treated as completion. Reset asserted during WAIT of entry 7: the next pass starts from tbl_index 0 with all outputs at their reset values.
